cdc_handshake_tx: RTL and testbench

Source-side endpoint of a four-phase req/ack clock-domain-crossing handshake, the transmitting counterpart to the synchronizer-based receiver in the bad-synchronizer experiment. It accepts a word from a valid/ready interface in its own clock domain, holds it stable on a bus to the far domain, and sequences `req_o` against an asynchronous `ack_i` that it synchronizes internally. It also counts completed transfers and flags protocol timeouts, so the bench can measure how often the receiving synchronizer misbehaves.

---
 rtl/cdc_handshake_tx.sv | 159 +++++++++++++++
 tb/tb_cdc_handshake_tx.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
// Transmit side of a four-phase req/ack CDC handshake with an ack synchronizer.
// Optional timeout/ERR logic is built only when CDC_TX_TIMEOUT_EN is defined.
module cdc_handshake_tx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              req_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ack_i,
    output logic              busy,
    output logic              err,
    input  logic              err_clr,
    output logic [7:0]        xfer_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_REL
`ifdef CDC_TX_TIMEOUT_EN
        , ST_ERR
`endif
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_ack_s;
    logic                   r_req;
    logic [DATA_W-1:0]      r_data;
    logic [7:0]             r_xfer_cnt;
    logic                   w_accept;
    logic                   w_done;
    logic                   w_tmo_hit;

    // ack_i is asynchronous: only the first flop of this chain may sample it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_i};
        end
    end

    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

`ifdef CDC_TX_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] r_tmo;
    logic                 r_err;

    // Firing one count early lets ERR and err register on the edge the count hits all-ones.
    assign w_tmo_hit = (r_tmo == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_state_next != r_state) begin
                r_tmo <= '0;
            end else if (r_state == ST_REQ || r_state == ST_REL) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_state_next == ST_ERR && r_state != ST_ERR) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign err = r_err;
`else
    logic w_unused;

    assign w_tmo_hit = 1'b0;
    assign w_unused  = w_tmo_hit | err_clr | (TIMEOUT_W > 0);
    assign err       = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_ack_s) begin
                    w_state_next = ST_REL;
                end
`ifdef CDC_TX_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_state_next = ST_ERR;
                end
`endif
            end
            ST_REL: begin
                if (!w_ack_s) begin
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end
`ifdef CDC_TX_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_state_next = ST_ERR;
                end
`endif
            end
`ifdef CDC_TX_TIMEOUT_EN
            ST_ERR: begin
                if (!w_ack_s) begin
                    w_state_next = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // req_o comes straight from a flop so the far domain never sees a glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_data     <= '0;
            r_xfer_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_req   <= (w_state_next == ST_REQ);
            if (w_accept) begin
                r_data <= in_data;
            end
            if (w_done) begin
                r_xfer_cnt <= r_xfer_cnt + 8'd1;
            end
        end
    end

    assign req_o    = r_req;
    assign data_o   = r_data;
    assign xfer_cnt = r_xfer_cnt;
    assign in_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: a randomized-latency far-side responder and a
// transfer-level model (expected word queue, expected completion count).
module tb_cdc_handshake_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       req_o;
    logic [7:0] data_o;
    logic       ack_i;
    logic       busy;
    logic       err;
    logic       err_clr = 1'b0;
    logic [7:0] xfer_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_xfers = 0;

    logic resp_follow = 1'b1;
    logic ack_force   = 1'b0;
    logic ack_del     = 1'b0;
    int   lat_max     = 0;
    int   wcnt        = 0;

    always #5 clk = ~clk;

    cdc_handshake_tx #(
        .DATA_W      (8),
        .SYNC_STAGES (2),
        .TIMEOUT_W   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .req_o    (req_o),
        .data_o   (data_o),
        .ack_i    (ack_i),
        .busy     (busy),
        .err      (err),
        .err_clr  (err_clr),
        .xfer_cnt (xfer_cnt)
    );

    // Far side: mirrors req_o after a random number of half-to-whole cycles.
    assign ack_i = resp_follow ? ack_del : ack_force;

    always @(negedge clk) begin
        if (!resp_follow) begin
            ack_del = 1'b0;
            wcnt    = 0;
        end else if (ack_del != req_o) begin
            if (wcnt == 0) begin
                ack_del = req_o;
                wcnt    = $urandom_range(0, lat_max);
            end else begin
                wcnt = wcnt - 1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (req_o !== 1'b0) $display("FAIL reset_req: got %b want 0", req_o); else n_pass++;
        n_checks++; if (data_o !== 8'h00) $display("FAIL reset_data: got %h want 00", data_o); else n_pass++;
        n_checks++; if (xfer_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", xfer_cnt); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        exp_xfers = 0;
        $display("reset: outputs checked");
    endtask

    task automatic test_single();
        int  req_cycles;
        bit  data_ok;
        @(negedge clk);
        resp_follow = 1'b1;
        lat_max = 0;
        in_data = 8'hA5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = 8'h00;
        n_checks++; if (data_o !== 8'hA5) $display("FAIL single_data_accept: got %h want a5", data_o); else n_pass++;
        n_checks++; if (req_o !== 1'b1) $display("FAIL single_req_accept: got %b want 1", req_o); else n_pass++;
        req_cycles = 1;
        data_ok = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (req_o) req_cycles++;
            if (data_o !== 8'hA5) data_ok = 1'b0;
            if (k == 5) begin
                n_checks++; if (xfer_cnt !== 8'd0) $display("FAIL single_cnt_early: got %0d want 0", xfer_cnt); else n_pass++;
            end
            if (k == 6) begin
                n_checks++; if (xfer_cnt !== 8'd1) $display("FAIL single_cnt_done: got %0d want 1", xfer_cnt); else n_pass++;
                n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_done: got %b want 0", busy); else n_pass++;
            end
        end
        exp_xfers++;
        n_checks++; if (req_cycles != 3) $display("FAIL single_req_len: got %0d want 3", req_cycles); else n_pass++;
        n_checks++; if (!data_ok) $display("FAIL single_data_stable: got unstable want a5"); else n_pass++;
        $display("single: word a5 req_cycles=%0d xfer_cnt=%0d", req_cycles, xfer_cnt);
    endtask

    task automatic test_back_to_back();
        int   exp_q[$];
        int   exp_w;
        int   idx;
        int   rises;
        int   dones;
        int   cycles;
        int   unstable;
        int   early_accepts;
        logic prev_req;
        logic prev_busy;
        logic [7:0] held;
        for (int i = 0; i < 300; i++) exp_q.push_back(i % 44);
        @(negedge clk);
        resp_follow = 1'b1;
        lat_max = 3;
        idx = 0; rises = 0; dones = 0; cycles = 0; unstable = 0; early_accepts = 0;
        prev_req = req_o;
        prev_busy = busy;
        held = data_o;
        while (dones < 300 && cycles < 8000) begin
            if (req_o && !prev_req) begin
                rises++;
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                n_checks++;
                if ({24'd0, data_o} !== exp_w) $display("FAIL b2b_word: got %h want %0h (word %0d)", data_o, exp_w, rises);
                else n_pass++;
                if (prev_busy) early_accepts++;
                held = data_o;
                $display("b2b: word %0d data=%h", rises, data_o);
            end else if (busy && data_o !== held) begin
                unstable++;
            end
            if (!busy && prev_busy) begin
                dones++;
                exp_xfers++;
                n_checks++;
                if (xfer_cnt !== exp_xfers[7:0]) $display("FAIL b2b_cnt: got %0d want %0d", xfer_cnt, exp_xfers[7:0]);
                else n_pass++;
            end
            prev_req = req_o;
            prev_busy = busy;
            if (idx < 300) begin
                in_valid = 1'b1;
                in_data = 8'(idx % 44);
                if (in_ready) idx++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        in_valid = 1'b0;
        n_checks++; if (dones != 300) $display("FAIL b2b_timeout: got %0d completions want 300", dones); else n_pass++;
        n_checks++; if (rises != 300) $display("FAIL b2b_accepts: got %0d want 300", rises); else n_pass++;
        n_checks++; if (unstable != 0) $display("FAIL b2b_data_stable: got %0d changes want 0", unstable); else n_pass++;
        n_checks++; if (early_accepts != 0) $display("FAIL b2b_idle_gap: got %0d early accepts want 0", early_accepts); else n_pass++;
        n_checks++; if (xfer_cnt !== exp_xfers[7:0]) $display("FAIL b2b_final_cnt: got %0d want %0d", xfer_cnt, exp_xfers[7:0]); else n_pass++;
    endtask

    task automatic test_stuck_ack();
        logic [7:0] word;
        int bad;
        int cycles;
        word = 8'($urandom);
        @(negedge clk);
        resp_follow = 1'b0;
        ack_force = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL stuck_ready: got %b want 1", in_ready); else n_pass++;
        in_data = word;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (req_o !== 1'b1 || data_o !== word) $display("FAIL stuck_accept: got req=%b data=%h want req=1 data=%h", req_o, data_o, word); else n_pass++;
        @(negedge clk);
        n_checks++; if (req_o !== 1'b0 || busy !== 1'b1) $display("FAIL stuck_req_len: got req=%b busy=%b want req=0 busy=1", req_o, busy); else n_pass++;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (req_o || !busy) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL stuck_hold_rel: got %0d bad cycles want 0", bad); else n_pass++;
        n_checks++; if (xfer_cnt !== exp_xfers[7:0]) $display("FAIL stuck_cnt_hold: got %0d want %0d", xfer_cnt, exp_xfers[7:0]); else n_pass++;
        ack_force = 1'b0;
        cycles = 0;
        while (busy && cycles < 10) begin
            @(negedge clk);
            cycles++;
        end
        exp_xfers++;
        n_checks++; if (busy !== 1'b0) $display("FAIL stuck_release_timeout: got busy=%b want 0", busy); else n_pass++;
        n_checks++; if (xfer_cnt !== exp_xfers[7:0]) $display("FAIL stuck_cnt_done: got %0d want %0d", xfer_cnt, exp_xfers[7:0]); else n_pass++;
        $display("stuck: word %h xfer_cnt=%0d", word, xfer_cnt);
    endtask

`ifdef CDC_TX_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] word;
        int req_cnt;
        int cycles;
        word = 8'($urandom);
        @(negedge clk);
        resp_follow = 1'b0;
        ack_force = 1'b0;
        repeat (3) @(negedge clk);
        in_data = word;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        req_cnt = 0;
        cycles = 0;
        while (req_o && cycles < 40) begin
            req_cnt++;
            @(negedge clk);
            cycles++;
        end
        n_checks++; if (req_cnt != 15) $display("FAIL tmo_req_len: got %0d want 15", req_cnt); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL tmo_err_set: got %b want 1", err); else n_pass++;
        n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL tmo_err_state: got ready=%b busy=%b want 0/1", in_ready, busy); else n_pass++;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL tmo_back_idle: got %b want 1", in_ready); else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++; if (err !== 1'b1) $display("FAIL tmo_err_sticky: got %b want 1", err); else n_pass++;
        n_checks++; if (xfer_cnt !== exp_xfers[7:0]) $display("FAIL tmo_cnt: got %0d want %0d", xfer_cnt, exp_xfers[7:0]); else n_pass++;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++; if (err !== 1'b0) $display("FAIL tmo_err_clr: got %b want 0", err); else n_pass++;
        $display("timeout: word %h req_cycles=%0d", word, req_cnt);
    endtask
`else
    task automatic test_no_timeout();
        logic [7:0] word;
        int bad_req;
        int bad_err;
        word = 8'($urandom);
        @(negedge clk);
        resp_follow = 1'b0;
        ack_force = 1'b0;
        in_data = word;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        bad_req = 0;
        bad_err = 0;
        for (int k = 0; k < 1000; k++) begin
            if (!req_o) bad_req++;
            if (err) bad_err++;
            err_clr = 1'($urandom);
            @(negedge clk);
        end
        err_clr = 1'b0;
        n_checks++; if (bad_req != 0) $display("FAIL noack_req_held: got %0d low cycles want 0", bad_req); else n_pass++;
        n_checks++; if (bad_err != 0) $display("FAIL noack_err_zero: got %0d high cycles want 0", bad_err); else n_pass++;
        n_checks++; if (data_o !== word) $display("FAIL noack_data: got %h want %h", data_o, word); else n_pass++;
        $display("noack: word %h req held 1000 cycles", word);
    endtask
`endif

    task automatic test_async_reset();
        logic [7:0] word;
        int cycles;
        @(negedge clk);
        resp_follow = 1'b0;
        ack_force = 1'b0;
        if (in_ready) begin
            in_data = 8'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (req_o !== 1'b1 || busy !== 1'b1) $display("FAIL arst_pre: got req=%b busy=%b want 1/1", req_o, busy); else n_pass++;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++; if (req_o !== 1'b0) $display("FAIL arst_req: got %b want 0", req_o); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (xfer_cnt !== 8'd0) $display("FAIL arst_cnt: got %0d want 0", xfer_cnt); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        exp_xfers = 0;
        repeat (2) @(negedge clk);
        n_checks++; if (xfer_cnt !== 8'd0) $display("FAIL arst_cnt_after: got %0d want 0", xfer_cnt); else n_pass++;
        word = 8'($urandom);
        resp_follow = 1'b1;
        lat_max = 2;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL arst_ready: got %b want 1", in_ready); else n_pass++;
        in_data = word;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (req_o !== 1'b1 || data_o !== word) $display("FAIL arst_next_accept: got req=%b data=%h want 1/%h", req_o, data_o, word); else n_pass++;
        cycles = 0;
        while (busy && cycles < 30) begin
            @(negedge clk);
            cycles++;
        end
        exp_xfers++;
        n_checks++; if (busy !== 1'b0) $display("FAIL arst_next_timeout: got busy=%b want 0", busy); else n_pass++;
        n_checks++; if (xfer_cnt !== exp_xfers[7:0]) $display("FAIL arst_next_cnt: got %0d want %0d", xfer_cnt, exp_xfers[7:0]); else n_pass++;
        $display("async_reset: next word %h xfer_cnt=%0d", word, xfer_cnt);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stuck_ack();
`ifdef CDC_TX_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
